// File: rtl/eg_pkg.sv
// Shared envelope-generator types: phase encoding, attenuation limit and
// the per-rate attenuation increment.
package eg_pkg;

  typedef enum logic [2:0] {
    ATTACK  = 3'd0,
    DECAY1  = 3'd1,
    DECAY2  = 3'd2,
    RELEASE = 3'd7
  } eg_state_t;

  localparam logic [9:0] EG_ATT_MAX = 10'h3FF;

  // Slow rates move by one step; the top four rate groups move faster.
  function automatic logic [3:0] inc_for_rate(input logic [5:0] rate);
    if (rate < 6'd48)          return 4'd1;
    else if (rate[5:2] == 4'd12) return 4'd2;
    else if (rate[5:2] == 4'd13) return 4'd4;
    else                       return 4'd8;
  endfunction

endpackage

// File: rtl/eg_rate_calc.sv
// Effective rate, counter shift and rate-counter phase for the current
// envelope phase. Purely combinational so the step decision downstream
// sees them in the same cycle.
module eg_rate_calc
  import eg_pkg::*;
(
  input  eg_state_t   state,
  input  logic [4:0]  ar,
  input  logic [4:0]  d1r,
  input  logic [4:0]  d2r,
  input  logic [3:0]  rr,
  input  logic [4:0]  keycode,
  input  logic [1:0]  ks,
  input  logic [11:0] eg_cnt,
  output logic [5:0]  rate,
  output logic [3:0]  shift,
  output logic [2:0]  cnt
);

  logic [4:0] base;
  logic [4:0] ks_term;
  logic [6:0] sum;

  // Select the phase rate, add key scaling and clamp to 63.
  always_comb begin
    base = 5'd0;
    case (state)
      ATTACK:  base = ar;
      DECAY1:  base = d1r;
      DECAY2:  base = d2r;
      default: base = {rr, 1'b1};
    endcase
    ks_term = keycode >> (2'd3 - ks);
    sum     = {1'b0, base, 1'b0} + {2'b00, ks_term};
    if (base == 5'd0)       rate = 6'd0;
    else if (sum > 7'd63)   rate = 6'd63;
    else                    rate = sum[5:0];
    shift = (rate < 6'd48) ? (4'd11 - rate[5:2]) : 4'd0;
    // bits above eg_cnt[11] read as zero for the slowest rates
    cnt   = 3'(eg_cnt >> shift);
  end

endmodule

// File: rtl/eg_att_ctrl.sv
// Envelope attenuation controller: phase FSM, tick divider, envelope
// counter and attenuation update.
//
// state   | meaning
// --------+------------------------------------------------------------
// ATTACK  | attenuation falls exponentially toward 0 (loudest)
// DECAY1  | attenuation rises linearly until it reaches the sustain level
// DECAY2  | attenuation keeps rising until saturation; held until keyon edge
// RELEASE | key released, attenuation rises to 0x3FF; reset state
module eg_att_ctrl
  import eg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        keyon,
  input  logic [4:0]  ar,
  input  logic [4:0]  d1r,
  input  logic [4:0]  d2r,
  input  logic [3:0]  rr,
  input  logic [3:0]  sl,
  input  logic [4:0]  keycode,
  input  logic [1:0]  ks,
  input  logic        step,
  output logic [2:0]  state,
  output logic [5:0]  rate,
  output logic [2:0]  cnt,
  output logic [9:0]  eg_att
);

  logic [1:0]  div;
  logic [11:0] eg_cnt;
  logic        kon_q;
  eg_state_t   state_q;
  logic [9:0]  att_q;
  logic [3:0]  shift;
  logic        eg_tick;
  logic        upd;
  logic [11:0] upd_mask;
  logic [3:0]  inc;
  logic [13:0] prod;
  logic [10:0] att_sum;
  logic [9:0]  att_step;
  logic [9:0]  att_upd;
  logic [4:0]  sl_lvl;
  logic        kon_rise;
  logic        kon_fall;

  eg_rate_calc u_rate_calc (
    .state   (state_q),
    .ar      (ar),
    .d1r     (d1r),
    .d2r     (d2r),
    .rr      (rr),
    .keycode (keycode),
    .ks      (ks),
    .eg_cnt  (eg_cnt),
    .rate    (rate),
    .shift   (shift),
    .cnt     (cnt)
  );

  assign state    = state_q;
  assign eg_att   = att_q;
  assign eg_tick  = clk_en && (div == 2'd2);
  assign upd_mask = (12'd1 << shift) - 12'd1;
  assign upd      = eg_tick && ((eg_cnt & upd_mask) == 12'd0);
  assign inc      = inc_for_rate(rate);
  assign sl_lvl   = (sl == 4'hF) ? 5'd31 : {sl, 1'b0};
  assign kon_rise = keyon && !kon_q;
  assign kon_fall = !keyon && kon_q;

  // Divide the sample enable by three and count envelope ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= 2'd0;
      eg_cnt <= 12'd0;
    end else if (clk_en) begin
      div <= (div == 2'd2) ? 2'd0 : div + 2'd1;
      if (eg_tick) eg_cnt <= eg_cnt + 12'd1;
    end
  end

  // Candidate attenuation after one step in the current phase.
  always_comb begin
    prod    = {4'd0, att_q} * {10'd0, inc};
    att_sum = {1'b0, att_q} + {7'd0, inc};
    if (state_q == ATTACK) begin
      // only att_q == 0 could go negative; every other value stays >= 0
      att_step = (att_q == 10'd0) ? 10'd0 : att_q - 10'(prod >> 4) - 10'd1;
    end else begin
      att_step = att_sum[10] ? EG_ATT_MAX : att_sum[9:0];
    end
    att_upd = (upd && step) ? att_step : att_q;
  end

  // Phase FSM: keyon edges win over any step; otherwise apply the step
  // and then test the phase exit against the updated attenuation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASE;
      att_q   <= EG_ATT_MAX;
      kon_q   <= 1'b0;
    end else if (clk_en) begin
      kon_q <= keyon;
      if (kon_rise) begin
        if (rate >= 6'd62) begin
          att_q   <= 10'd0;
          state_q <= DECAY1;
        end else begin
          state_q <= ATTACK;
        end
      end else if (kon_fall) begin
        state_q <= RELEASE;
      end else begin
        att_q <= att_upd;
        case (state_q)
          ATTACK:  if (att_upd == 10'd0) state_q <= DECAY1;
          DECAY1:  if (att_upd[9:5] >= sl_lvl) state_q <= DECAY2;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eg_att_ctrl.sv
// Bench for eg_att_ctrl: directed scenarios plus randomized traffic, all
// checked against an arithmetic envelope model.
module tb_eg_att_ctrl;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        keyon;
  logic [4:0]  ar;
  logic [4:0]  d1r;
  logic [4:0]  d2r;
  logic [3:0]  rr;
  logic [3:0]  sl;
  logic [4:0]  keycode;
  logic [1:0]  ks;
  logic        step;
  logic [2:0]  state;
  logic [5:0]  rate;
  logic [2:0]  cnt;
  logic [9:0]  eg_att;

  eg_att_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .keyon   (keyon),
    .ar      (ar),
    .d1r     (d1r),
    .d2r     (d2r),
    .rr      (rr),
    .sl      (sl),
    .keycode (keycode),
    .ks      (ks),
    .step    (step),
    .state   (state),
    .rate    (rate),
    .cnt     (cnt),
    .eg_att  (eg_att)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // model state
  int m_state, m_att, m_egcnt, m_div, m_kon;
  int m_rate, m_shift, m_cnt, m_upd_count;
  bit step_en;

  logic [21:0] dut_vec;
  assign dut_vec = {state, eg_att, rate, cnt};

  function automatic logic [21:0] model_vec();
    return {3'(m_state), 10'(m_att), 6'(m_rate), 3'(m_cnt)};
  endfunction

  // combinational view of the model; also drives the step decision
  task automatic model_comb();
    int base, kc;
    case (m_state)
      0:       base = ar;
      1:       base = d1r;
      2:       base = d2r;
      default: base = rr * 2 + 1;
    endcase
    kc = keycode;
    if (base == 0) m_rate = 0;
    else begin
      m_rate = base * 2 + (kc >> (3 - int'(ks)));
      if (m_rate > 63) m_rate = 63;
    end
    m_shift = (m_rate < 48) ? 11 - m_rate / 4 : 0;
    m_cnt   = (m_egcnt >> m_shift) % 8;
    step    = (m_rate != 0) && step_en;
  endtask

  // one clock edge of the model
  task automatic model_seq();
    bit tk, up, rise, fall;
    int inc, lvl;
    if (!clk_en) return;
    tk   = (m_div == 2);
    up   = tk && ((m_egcnt % (1 << m_shift)) == 0);
    rise = keyon && (m_kon == 0);
    fall = !keyon && (m_kon == 1);
    inc  = (m_rate < 48) ? 1 : (m_rate < 52) ? 2 : (m_rate < 56) ? 4 : 8;
    lvl  = (sl == 15) ? 31 : sl * 2;
    if (rise) begin
      if (m_rate >= 62) begin m_att = 0; m_state = 1; end
      else m_state = 0;
    end else if (fall) begin
      m_state = 7;
    end else begin
      if (up && step) begin
        m_upd_count++;
        if (m_state == 0) begin
          m_att = m_att - (m_att * inc) / 16 - 1;
          if (m_att < 0) m_att = 0;
        end else begin
          m_att = m_att + inc;
          if (m_att > 1023) m_att = 1023;
        end
      end
      if (m_state == 0 && m_att == 0) m_state = 1;
      else if (m_state == 1 && m_att / 32 >= lvl) m_state = 2;
    end
    m_kon = keyon ? 1 : 0;
    m_div = (m_div + 1) % 3;
    if (tk) m_egcnt = (m_egcnt + 1) % 4096;
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    model_seq();
    #1;
    model_comb();
  endtask

  task automatic do_reset(input logic kon);
    rst_n = 1'b0; keyon = kon; clk_en = 1'b1; step_en = 1'b0;
    m_state = 7; m_att = 1023; m_egcnt = 0; m_div = 0; m_kon = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 model_comb();
  endtask

  task automatic test_reset();
    ar = 5'd31; rr = 4'd15; d1r = 5'd31; d2r = 5'd0; sl = 4'd4;
    keycode = 5'd0; ks = 2'd0;
    do_reset(1'b0);
    n_total++;
    if ({state, eg_att} !== {3'd7, 10'h3FF})
      $display("FAIL reset_values: got state=%0d att=%h want state=7 att=3ff", state, eg_att);
    else n_pass++;
    n_total++;
    if (dut_vec !== model_vec()) $display("FAIL reset_vec: got %h want %h", dut_vec, model_vec());
    else n_pass++;
    keyon = 1'b1;
    tick();
    n_total++;
    if (dut_vec !== model_vec()) $display("FAIL reset_keyon: got %h want %h", dut_vec, model_vec());
    else n_pass++;
    rst_n = 1'b0;
    #2;
    n_total++;
    if ({state, eg_att} !== {3'd7, 10'h3FF})
      $display("FAIL async_reset: got state=%0d att=%h want state=7 att=3ff", state, eg_att);
    else n_pass++;
  endtask

  task automatic test_instant_attack();
    ar = 5'd31; rr = 4'd15; d1r = 5'd31; sl = 4'd4;
    do_reset(1'b1);
    tick();
    n_total++;
    if ({state, eg_att} !== {3'd1, 10'h000})
      $display("FAIL instant_attack: got state=%0d att=%h want state=1 att=000", state, eg_att);
    else n_pass++;
    n_total++;
    if (dut_vec !== model_vec()) $display("FAIL instant_attack_vec: got %h want %h", dut_vec, model_vec());
    else n_pass++;
  endtask

  task automatic test_decay1();
    bit done;
    done = 1'b0;
    step_en = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      n_total++;
      if (dut_vec !== model_vec()) $display("FAIL decay1_vec: got %h want %h", dut_vec, model_vec());
      else n_pass++;
      if (state == 3'd2) done = 1'b1;
    end
    n_total++;
    if (!done) $display("FAIL decay1_timeout: got state=%0d want state=2", state);
    else if (eg_att[9:5] !== 5'd8) $display("FAIL decay1_level: got att[9:5]=%0d want 8", eg_att[9:5]);
    else n_pass++;
  endtask

  task automatic test_attack_ar10();
    logic [9:0] prev;
    bit done;
    ar = 5'd10; rr = 4'd0; d1r = 5'd0; sl = 4'd4;
    do_reset(1'b0);
    keyon = 1'b1; step_en = 1'b1;
    tick();
    n_total++;
    if ({state, eg_att, rate} !== {3'd0, 10'h3FF, 6'd20})
      $display("FAIL attack_start: got state=%0d att=%h rate=%0d want 0 3ff 20", state, eg_att, rate);
    else n_pass++;
    prev = eg_att;
    done = 1'b0;
    for (int i = 0; i < 25000 && !done; i++) begin
      tick();
      n_total++;
      if (dut_vec !== model_vec() || eg_att > prev)
        $display("FAIL attack_fall: got %h prev_att=%h want %h", dut_vec, prev, model_vec());
      else n_pass++;
      prev = eg_att;
      if (state != 3'd0) done = 1'b1;
    end
    n_total++;
    if ({state, eg_att} !== {3'd1, 10'h000})
      $display("FAIL attack_end: got state=%0d att=%h want state=1 att=000", state, eg_att);
    else n_pass++;
    repeat (12) begin
      tick();
      n_total++;
      if (dut_vec !== model_vec() || rate !== 6'd0 || eg_att !== 10'h000)
        $display("FAIL rate_zero_hold: got %h want %h", dut_vec, model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_release();
    logic [9:0] prev;
    bit done;
    ar = 5'd31; rr = 4'd15; d1r = 5'd31; sl = 4'd15;
    do_reset(1'b1);
    tick();
    step_en = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      n_total++;
      if (dut_vec !== model_vec()) $display("FAIL rel_setup: got %h want %h", dut_vec, model_vec());
      else n_pass++;
      if (eg_att == 10'h200) done = 1'b1;
    end
    step_en = 1'b0; keyon = 1'b0;
    tick();
    rr = 4'd0; ar = 5'd1; keyon = 1'b1;
    tick();
    n_total++;
    if ({state, eg_att} !== {3'd0, 10'h200})
      $display("FAIL rel_attack_200: got state=%0d att=%h want state=0 att=200", state, eg_att);
    else n_pass++;
    keyon = 1'b0; rr = 4'd15; step_en = 1'b1;
    tick();
    n_total++;
    if ({state, eg_att} !== {3'd7, 10'h200})
      $display("FAIL rel_enter: got state=%0d att=%h want state=7 att=200", state, eg_att);
    else n_pass++;
    prev = eg_att;
    for (int i = 0; i < 400 && eg_att != 10'h3FF; i++) begin
      tick();
      n_total++;
      if (dut_vec !== model_vec() || eg_att < prev)
        $display("FAIL rel_rise: got %h prev_att=%h want %h", dut_vec, prev, model_vec());
      else n_pass++;
      prev = eg_att;
    end
    repeat (9) tick();
    n_total++;
    if ({state, eg_att} !== {3'd7, 10'h3FF})
      $display("FAIL rel_saturate: got state=%0d att=%h want state=7 att=3ff", state, eg_att);
    else n_pass++;
  endtask

  task automatic test_edge_priority();
    logic [9:0] saved;
    ar = 5'd31; rr = 4'd15;
    do_reset(1'b1);
    tick();
    keyon = 1'b0; rr = 4'd14; step_en = 1'b1;
    tick();
    for (int i = 0; i < 40 && !(m_att > 0 && m_div == 2); i++) begin
      tick();
      n_total++;
      if (dut_vec !== model_vec()) $display("FAIL prio_setup: got %h want %h", dut_vec, model_vec());
      else n_pass++;
    end
    keyon = 1'b1;
    saved = eg_att;
    model_comb();
    n_total++;
    if (rate !== 6'd58 || step !== 1'b1 || m_div != 2)
      $display("FAIL prio_precond: got rate=%0d step=%0d div=%0d want 58 1 2", rate, step, m_div);
    else n_pass++;
    tick();
    n_total++;
    if ({state, eg_att} !== {3'd0, saved})
      $display("FAIL prio_edge: got state=%0d att=%h want state=0 att=%h", state, eg_att, saved);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [9:0] prev;
    int dut_steps, prev_cnt, after;
    bit wrapped;
    ar = 5'd31; rr = 4'd15; d1r = 5'd31; d2r = 5'd10; sl = 4'd0;
    do_reset(1'b1);
    tick();
    tick();
    step_en = 1'b1;
    m_upd_count = 0; dut_steps = 0; wrapped = 1'b0; after = 0;
    prev = eg_att;
    for (int i = 0; i < 14000 && after < 300; i++) begin
      prev_cnt = m_egcnt;
      tick();
      n_total++;
      if (dut_vec !== model_vec()) $display("FAIL wrap_vec: got %h want %h", dut_vec, model_vec());
      else n_pass++;
      if (eg_att != prev) dut_steps++;
      prev = eg_att;
      if (prev_cnt == 4095 && m_egcnt == 0) wrapped = 1'b1;
      if (wrapped) after++;
    end
    n_total++;
    if (!wrapped || dut_steps != m_upd_count || state !== 3'd2)
      $display("FAIL wrap_updates: got wrapped=%0d steps=%0d state=%0d want 1 %0d 2",
               wrapped, dut_steps, state, m_upd_count);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 5000; i++) begin
      if (i % 64 == 0) begin
        ar = 5'($urandom); d1r = 5'($urandom); d2r = 5'($urandom);
        rr = 4'($urandom); sl = 4'($urandom);
        keycode = 5'($urandom); ks = 2'($urandom);
      end
      if ($urandom_range(0, 49) == 0) keyon = ~keyon;
      clk_en  = ($urandom_range(0, 3) != 0);
      step_en = ($urandom_range(0, 3) != 0);
      tick();
      n_total++;
      if (dut_vec !== model_vec()) $display("FAIL random_vec: got %h want %h", dut_vec, model_vec());
      else n_pass++;
    end
    clk_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; keyon = 1'b0; step = 1'b0; step_en = 1'b0;
    ar = '0; d1r = '0; d2r = '0; rr = '0; sl = '0; keycode = '0; ks = '0;
    m_upd_count = 0;
    test_reset();
    test_instant_attack();
    test_decay1();
    test_attack_ar10();
    test_release();
    test_edge_priority();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/eg_att_ctrl.md
EG_ATT_CTRL -- requirements
Module: eg_att_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first; all inputs other than clk and rst_n are sampled on clk:
- clk  in  1  single core clock; one clock, all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clk_en  in  1  sample-rate enable; all state advances only when high.
- keyon  in  1  operator key state, level.
- ar  in  5  attack rate.
- d1r  in  5  first decay rate.
- d2r  in  5  second decay rate.
- rr  in  4  release rate.
- sl  in  4  sustain level.
- keycode  in  5  block/note key code.
- ks  in  2  key-scale setting.
- step  in  1  step decision returned combinationally by the downstream step-decision stage for the current rate, cnt and state.
- state  out  3  envelope phase: ATTACK=0, DECAY1=1, DECAY2=2, RELEASE=7.
- rate  out  6  effective rate, to the step-decision stage.
- cnt  out  3  rate-counter phase, to the step-decision stage.
- eg_att  out  10  attenuation, 0 = loudest, 0x3FF = silent.

Function
REQ-002 SHALL divide clk_en by 3 to form eg_tick: a 2-bit divider counts 0,1,2,0; eg_tick is asserted on the clk_en cycle where the divider equals 2.
REQ-003 SHALL hold a 12-bit eg_cnt that increments on eg_tick and wraps from 0xFFF to 0.
REQ-004 SHALL compute rate combinationally:
- base = ar, d1r or d2r per state; base = rr*2+1 in RELEASE.
- base==0 gives rate 0.
- otherwise rate = min(63, base*2 + (keycode >> (3-ks))).
REQ-005 SHALL compute shift = (rate<48) ? 11 - rate[5:2] : 0, and cnt = eg_cnt[shift+2 : shift].
REQ-006 SHALL define upd = eg_tick AND (eg_cnt mod 2^shift == 0).
REQ-007 SHALL use inc = 1 for rate<48; inc = 2, 4, 8, 8 for rate[5:2] = 12, 13, 14, 15.
REQ-008 SHALL, when upd and step are both high, update eg_att by state:
- ATTACK: eg_att - ((eg_att*inc)>>4) - 1, floored at 0.
- DECAY1, DECAY2, RELEASE: eg_att + inc, saturated at 0x3FF.
REQ-009 SHALL detect keyon edges against a registered copy updated on clk_en.
REQ-010 SHALL, on a keyon rising edge:
- with rate>=62: set eg_att=0 and state=DECAY1;
- otherwise: set state=ATTACK and keep eg_att unchanged.
REQ-011 SHALL, on a keyon falling edge, set state=RELEASE from any state, keeping eg_att.
REQ-012 SHALL give a keyon edge priority over a simultaneous step update; no step is applied in that cycle.
REQ-013 SHALL apply these transitions, each evaluated after the REQ-008 update in the same clk_en cycle:
- ATTACK to DECAY1 when eg_att reaches 0.
- DECAY1 to DECAY2 when eg_att[9:5] >= sl_lvl, where sl_lvl = 31 for sl==15 and sl*2 otherwise.
REQ-014 SHALL hold DECAY2 and RELEASE until a keyon edge; eg_att saturates at 0x3FF.
REQ-015 SHALL drive state and eg_att from registers; rate and cnt are combinational, so step has zero-cycle latency.
REQ-016 SHALL freeze all registers while clk_en is low.

Reset
REQ-017 SHALL, while rst_n is low, asynchronously force: state=RELEASE, eg_att=0x3FF, eg_cnt=0, divider=0, keyon register=0.
REQ-018 SHALL, after rst_n deasserts with keyon already high, treat the first clk_en as a rising edge.

Structure
REQ-019 SHALL take state encodings and the 0x3FF maximum from shared package eg_pkg.
REQ-020 SHALL place REQ-004/005 in one combinational sub-module, eg_rate_calc.

Verification
REQ-021 SHALL cover these directed scenarios (keycode=0, ks=0 unless stated):
- Reset, then keyon=1 with ar=31: eg_att=0 and state=DECAY1 on the first clk_en.
- ar=10 (rate 20): eg_att falls monotonically from 0x3FF to 0, then state=DECAY1; step is low whenever rate==0.
- d1r=31, sl=4: state moves DECAY1 to DECAY2 exactly when eg_att[9:5] reaches 8.
- keyon falls mid-ATTACK at eg_att=0x200: state=RELEASE, eg_att rises from 0x200 and saturates at 0x3FF.
- keyon rises coincident with an upd&step cycle: eg_att is unchanged in that cycle.
- eg_cnt wraps from 0xFFF to 0: cnt and upd stay continuous with no missed or doubled update.
